branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver_pkg.sv | 25 ++
 rtl/branch_resolver_btb_table.sv | 57 +++++
 rtl/branch_resolver.sv | 122 ++++++++++++
 tb/tb_branch_resolver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: shared encodings, state/resolution enums and counter helpers
package branch_resolver_pkg;
   typedef enum logic [1:0] {
      MODE_STATIC  = 2'd0,
      MODE_BIMODAL = 2'd1,
      MODE_GSHARE  = 2'd2,
      MODE_RSVD    = 2'd3
   } mode_e;
   typedef enum logic {ST_IDLE, ST_CLEAR} state_e;
   typedef enum logic [2:0] {
      RES_NONE,
      RES_OK,
      RES_MISS_T,
      RES_MISS_NT,
      RES_BAD_TGT,
      RES_NONBR
   } res_e;
   localparam logic [1:0] CTR_MIN   = 2'b00;
   localparam logic [1:0] CTR_RESET = 2'b01;
   localparam logic [1:0] CTR_ALLOC = 2'b10;
   localparam logic [1:0] CTR_MAX   = 2'b11;
   function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic t);
      return t ? ((c == CTR_MAX) ? c : c + 2'd1) : ((c == CTR_MIN) ? c : c - 2'd1);
   endfunction
endpackage

// File: rtl/branch_resolver_btb_table.sv
// btb_table: valid/tag/target/counter storage, combinational read, read-modify-write update port
module btb_table
   import branch_resolver_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4,
   parameter int TAG_W   = 26,
   parameter int PC_W    = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [IDX_W-1:0] rd_idx_i,
   output logic             rd_valid_o,
   output logic [TAG_W-1:0] rd_tag_o,
   output logic [PC_W-1:0]  rd_target_o,
   output logic             rd_taken_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic [TAG_W-1:0] wr_tag_i,
   input  logic             wr_taken_i,
   input  logic [PC_W-1:0]  wr_target_i,
   input  logic             inv_en_i,
   input  logic [IDX_W-1:0] inv_idx_i
);
   logic [ENTRIES-1:0] valid_q;
   logic [1:0]         ctr_q [ENTRIES];
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [PC_W-1:0]    tgt_q [ENTRIES];
   logic               wr_hit;

   assign rd_valid_o  = valid_q[rd_idx_i];
   assign rd_tag_o    = tag_q[rd_idx_i];
   assign rd_target_o = tgt_q[rd_idx_i];
   assign rd_taken_o  = ctr_q[rd_idx_i][1];
   assign wr_hit      = valid_q[wr_idx_i] && (tag_q[wr_idx_i] == wr_tag_i);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RESET;
      end else begin
         if (wr_en_i && (wr_hit || wr_taken_i)) begin
            ctr_q[wr_idx_i]   <= wr_hit ? ctr_next(ctr_q[wr_idx_i], wr_taken_i) : CTR_ALLOC;
            valid_q[wr_idx_i] <= 1'b1;
         end
         if (inv_en_i) valid_q[inv_idx_i] <= 1'b0;
      end
   end

   // a taken update either refreshes a hit (same tag) or allocates, so both rewrite tag and target
   always_ff @(posedge clk) begin
      if (wr_en_i && wr_taken_i) begin
         tag_q[wr_idx_i] <= wr_tag_i;
         tgt_q[wr_idx_i] <= wr_target_i;
      end
   end
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: BTB/PHT fetch prediction, execute-stage resolution/redirect, table clear FSM, stats
module branch_resolver
   import branch_resolver_pkg::*;
#(
   parameter int PC_W    = 32,
   parameter int ENTRIES = 16,
   parameter int GHR_W   = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       mode,
   input  logic             f_valid,
   input  logic [PC_W-1:0]  f_pc,
   output logic             f_pred_taken,
   output logic [PC_W-1:0]  f_pred_target,
   output logic [GHR_W-1:0] f_ghr,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic [PC_W-1:0]  ex_pc,
   input  logic             ex_taken,
   input  logic [PC_W-1:0]  ex_target,
   input  logic             ex_pred_taken,
   input  logic [PC_W-1:0]  ex_pred_target,
   input  logic [GHR_W-1:0] ex_ghr,
   output logic             redirect,
   output logic [PC_W-1:0]  redirect_pc,
   input  logic             tbl_clear,
   output logic             busy,
   input  logic             stat_clr,
   output logic [31:0]      branch_cnt,
   output logic [31:0]      mispred_cnt
);
   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_W - IDX_W - 2;

   state_e           st_q, st_d;
   logic [IDX_W-1:0] clr_q, clr_d;
   logic [GHR_W-1:0] ghr_q, ghr_d;
   logic [31:0]      branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;
   res_e             res;
   logic             gshare, resolve, rd_valid, rd_taken, rd_hit;
   logic [IDX_W-1:0] f_idx, ex_idx;
   logic [TAG_W-1:0] rd_tag;
   logic [PC_W-1:0]  rd_target;

   assign gshare  = (mode == MODE_GSHARE);
   assign f_idx   = f_pc[IDX_W+1:2] ^ (gshare ? IDX_W'(ghr_q) : '0);
   assign ex_idx  = ex_pc[IDX_W+1:2] ^ (gshare ? IDX_W'(ex_ghr) : '0);
   assign busy    = (st_q == ST_CLEAR);
   assign resolve = ex_valid && ex_is_branch;
   assign rd_hit  = rd_valid && (rd_tag == f_pc[PC_W-1:IDX_W+2]);

   assign f_pred_taken  = f_valid && (mode == MODE_BIMODAL || gshare) && rd_hit && rd_taken && !busy;
   assign f_pred_target = f_pred_taken ? rd_target : f_pc + PC_W'(4);
   assign f_ghr         = ghr_q;
   assign branch_cnt    = branch_cnt_q;
   assign mispred_cnt   = mispred_cnt_q;

   btb_table #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W), .PC_W(PC_W)) u_btb (
      .clk        (clk),
      .reset_n    (reset_n),
      .rd_idx_i   (f_idx),
      .rd_valid_o (rd_valid),
      .rd_tag_o   (rd_tag),
      .rd_target_o(rd_target),
      .rd_taken_o (rd_taken),
      .wr_en_i    (resolve && !busy),
      .wr_idx_i   (ex_idx),
      .wr_tag_i   (ex_pc[PC_W-1:IDX_W+2]),
      .wr_taken_i (ex_taken),
      .wr_target_i(ex_target),
      .inv_en_i   (busy || (res == RES_NONBR)),
      .inv_idx_i  (busy ? clr_q : ex_idx)
   );

   always_comb begin
      res = RES_NONE;
      if (resolve)
         res = !ex_pred_taken ? (ex_taken ? RES_MISS_T : RES_OK)
             : !ex_taken ? RES_MISS_NT
             : (ex_target == ex_pred_target) ? RES_OK : RES_BAD_TGT;
      else if (ex_valid && ex_pred_taken)
         res = RES_NONBR;
   end

   assign redirect    = (res == RES_MISS_T) || (res == RES_MISS_NT) || (res == RES_BAD_TGT) || (res == RES_NONBR);
   assign redirect_pc = (res == RES_MISS_NT || res == RES_NONBR) ? ex_pc + PC_W'(4) : ex_target;

   always_comb begin
      st_d  = st_q;
      clr_d = '0;
      if (st_q == ST_IDLE) begin
         if (tbl_clear) st_d = ST_CLEAR;
      end else begin
         clr_d = clr_q + 1'b1;
         if (clr_q == IDX_W'(ENTRIES - 1)) st_d = ST_IDLE;
      end
   end

   // redirect repairs history from the fetch-time snapshot, overriding speculative shifts
   assign ghr_d = redirect ? ((res == RES_NONBR) ? ex_ghr : {ex_ghr[GHR_W-2:0], ex_taken})
                : (f_valid && rd_hit) ? {ghr_q[GHR_W-2:0], f_pred_taken} : ghr_q;

   assign branch_cnt_d  = stat_clr ? '0 : (resolve && ~&branch_cnt_q) ? branch_cnt_q + 32'd1 : branch_cnt_q;
   assign mispred_cnt_d = stat_clr ? '0 : (redirect && ~&mispred_cnt_q) ? mispred_cnt_q + 32'd1 : mispred_cnt_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         st_q          <= ST_IDLE;
         clr_q         <= '0;
         ghr_q         <= '0;
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         st_q          <= st_d;
         clr_q         <= clr_d;
         ghr_q         <= ghr_d;
         branch_cnt_q  <= branch_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vectors with hand-computed expectations for branch_resolver
module tb_branch_resolver;
   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  mode;
   logic        f_valid;
   logic [31:0] f_pc;
   logic        f_pred_taken;
   logic [31:0] f_pred_target;
   logic [3:0]  f_ghr;
   logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
   logic [31:0] ex_pc, ex_target, ex_pred_target;
   logic [3:0]  ex_ghr;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        tbl_clear, busy, stat_clr;
   logic [31:0] branch_cnt, mispred_cnt;
   int          checks = 0;
   int          failures = 0;
   int          n;
   logic [31:0] clr_pcs [4] = '{32'h100, 32'h104, 32'h108, 32'h10C};

   always #5 clk = ~clk;

   branch_resolver #(.PC_W(32), .ENTRIES(16), .GHR_W(4)) dut (
      .clk(clk), .reset_n(reset_n), .mode(mode),
      .f_valid(f_valid), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
      .f_pred_target(f_pred_target), .f_ghr(f_ghr),
      .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_pc(ex_pc),
      .ex_taken(ex_taken), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
      .ex_pred_target(ex_pred_target), .ex_ghr(ex_ghr),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .tbl_clear(tbl_clear), .busy(busy), .stat_clr(stat_clr),
      .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
      f_valid = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0; ex_pred_taken = 1'b0;
      tbl_clear = 1'b0; stat_clr = 1'b0;
   endtask

   task automatic fetch(input logic [31:0] pc);
      f_valid = 1'b1; f_pc = pc; #1;
   endtask

   task automatic br(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                     input logic pt, input logic [31:0] ptgt, input logic [3:0] g);
      f_valid = 1'b0; ex_valid = 1'b1; ex_is_branch = 1'b1; ex_pc = pc; ex_taken = tk;
      ex_target = tgt; ex_pred_taken = pt; ex_pred_target = ptgt; ex_ghr = g; #1;
   endtask

   task automatic nonbr(input logic [31:0] pc, input logic [3:0] g);
      f_valid = 1'b0; ex_valid = 1'b1; ex_is_branch = 1'b0; ex_pc = pc; ex_taken = 1'b0;
      ex_pred_taken = 1'b1; ex_ghr = g; #1;
   endtask

   initial begin
      reset_n = 1'b0; mode = 2'd1; f_valid = 1'b1; f_pc = 32'h100;
      ex_valid = 0; ex_is_branch = 0; ex_taken = 0; ex_pred_taken = 0;
      ex_pc = 0; ex_target = 0; ex_pred_target = 0; ex_ghr = 0;
      tbl_clear = 0; stat_clr = 0;
      #7;
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_pred", {31'd0, f_pred_taken}, 0);
      chk("rst_redirect", {31'd0, redirect}, 0);
      chk("rst_ghr", {28'd0, f_ghr}, 0);
      chk("rst_bcnt", branch_cnt, 0);
      chk("rst_mcnt", mispred_cnt, 0);
      #5 reset_n = 1'b1;
      step;
      fetch(32'h100);
      chk("cold_pred", {31'd0, f_pred_taken}, 0);
      chk("cold_tgt", f_pred_target, 32'h104);
      // first taken resolve allocates with weakly-taken counter
      br(32'h100, 1, 32'h200, 0, 32'h0, 4'h0);
      chk("ntt_redir", {31'd0, redirect}, 1);
      chk("ntt_pc", redirect_pc, 32'h200);
      step;
      fetch(32'h100);
      chk("alloc_pred", {31'd0, f_pred_taken}, 1);
      chk("alloc_tgt", f_pred_target, 32'h200);
      chk("alloc_ghr", {28'd0, f_ghr}, 4'b0001);
      chk("alloc_bcnt", branch_cnt, 1);
      chk("alloc_mcnt", mispred_cnt, 1);
      br(32'h100, 1, 32'h200, 1, 32'h200, 4'h0);
      chk("tt_ok_redir", {31'd0, redirect}, 0);
      step;
      br(32'h100, 0, 32'h200, 1, 32'h200, 4'h0);
      chk("tnt_redir", {31'd0, redirect}, 1);
      chk("tnt_pc", redirect_pc, 32'h104);
      step;
      fetch(32'h100);
      chk("ctr10_pred", {31'd0, f_pred_taken}, 1);
      chk("tnt_mcnt", mispred_cnt, 2);
      br(32'h100, 0, 32'h200, 1, 32'h200, 4'h0);
      step;
      fetch(32'h100);
      chk("ctr01_pred", {31'd0, f_pred_taken}, 0);
      chk("ctr01_tgt", f_pred_target, 32'h104);
      br(32'h100, 1, 32'h200, 0, 32'h0, 4'h0);
      step;
      br(32'h100, 1, 32'h300, 1, 32'h200, 4'h0);
      chk("badtgt_redir", {31'd0, redirect}, 1);
      chk("badtgt_pc", redirect_pc, 32'h300);
      step;
      fetch(32'h100);
      chk("newtgt_pred", {31'd0, f_pred_taken}, 1);
      chk("newtgt_tgt", f_pred_target, 32'h300);
      mode = 2'd0; #1;
      chk("mode0_pred", {31'd0, f_pred_taken}, 0);
      chk("mode0_tgt", f_pred_target, 32'h104);
      mode = 2'd3; #1;
      chk("mode3_pred", {31'd0, f_pred_taken}, 0);
      mode = 2'd1; #1;
      chk("mode1_back", f_pred_target, 32'h300);
      br(32'h140, 1, 32'h180, 0, 32'h0, 4'h0);
      step;
      fetch(32'h140);
      chk("b140_pred", {31'd0, f_pred_taken}, 1);
      chk("b140_tgt", f_pred_target, 32'h180);
      nonbr(32'h140, 4'b0011);
      chk("nonbr_redir", {31'd0, redirect}, 1);
      chk("nonbr_pc", redirect_pc, 32'h144);
      step;
      fetch(32'h140);
      chk("nonbr_inv", {31'd0, f_pred_taken}, 0);
      chk("nonbr_ghr", {28'd0, f_ghr}, 4'b0011);
      chk("nonbr_bcnt", branch_cnt, 7);
      chk("nonbr_mcnt", mispred_cnt, 7);
      br(32'h104, 1, 32'h400, 0, 32'h0, 4'h0);
      step;
      br(32'h108, 1, 32'h500, 0, 32'h0, 4'h0);
      step;
      fetch(32'h104);
      chk("pre_clr_pred", {31'd0, f_pred_taken}, 1);
      f_valid = 1'b0; tbl_clear = 1'b1;
      step;
      chk("clr_busy", {31'd0, busy}, 1);
      fetch(32'h104);
      chk("busy_pred", {31'd0, f_pred_taken}, 0);
      f_valid = 1'b0;
      n = 0;
      while (busy && n < 40) begin
         tbl_clear = (n == 5);
         if (n == 15) begin
            br(32'h10C, 1, 32'h600, 0, 32'h0, 4'h0);
            chk("busy_redir", {31'd0, redirect}, 1);
            chk("busy_redir_pc", redirect_pc, 32'h600);
         end
         step;
         n++;
      end
      chk("busy_cycles", n, 16);
      chk("clr_done", {31'd0, busy}, 0);
      for (int i = 0; i < 4; i++) begin
         fetch(clr_pcs[i]);
         chk("post_clr_pred", {31'd0, f_pred_taken}, 0);
      end
      chk("clr_bcnt", branch_cnt, 10);
      chk("clr_mcnt", mispred_cnt, 10);
      mode = 2'd2;
      br(32'h200, 1, 32'h800, 0, 32'h0, 4'b1010);
      chk("gs_redir_pc", redirect_pc, 32'h800);
      step;
      chk("gs_ghr", {28'd0, f_ghr}, 4'b0101);
      nonbr(32'h004, 4'b1010);
      step;
      fetch(32'h200);
      chk("gs_ghr2", {28'd0, f_ghr}, 4'b1010);
      chk("gs_pred", {31'd0, f_pred_taken}, 1);
      chk("gs_tgt", f_pred_target, 32'h800);
      mode = 2'd1; #1;
      chk("bim_noalias", {31'd0, f_pred_taken}, 0);
      f_valid = 1'b0;
      force dut.branch_cnt_q = 32'hFFFFFFFE;
      force dut.mispred_cnt_q = 32'hFFFFFFFE;
      #1;
      release dut.branch_cnt_q;
      release dut.mispred_cnt_q;
      br(32'h100, 1, 32'h900, 0, 32'h0, 4'h0);
      step;
      chk("sat1_bcnt", branch_cnt, 32'hFFFFFFFF);
      chk("sat1_mcnt", mispred_cnt, 32'hFFFFFFFF);
      br(32'h100, 0, 32'h900, 1, 32'h900, 4'h0);
      step;
      chk("sat2_bcnt", branch_cnt, 32'hFFFFFFFF);
      chk("sat2_mcnt", mispred_cnt, 32'hFFFFFFFF);
      br(32'h100, 1, 32'h900, 0, 32'h0, 4'h0);
      stat_clr = 1'b1;
      step;
      chk("sclr_bcnt", branch_cnt, 0);
      chk("sclr_mcnt", mispred_cnt, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
